// File: rtl/cpu_pkg.sv
// Shared CPU writeback types: architectural register/data widths and the
// {rd, data} write request carried from producers to the register file.
package cpu_pkg;

  localparam int D_WIDTH  = 32;
  localparam int N_REGS   = 32;
  localparam int REG_L2   = $clog2(N_REGS);
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic [REG_L2-1:0]  rd;
    logic [D_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_arb_if.sv
// Writeback bus: ALU and LSU result handshakes plus the register-file write port.
// master = producers/register file side, slave = the writeback arbiter.
interface rf_wb_arb_if #(
  parameter int D_WIDTH    = cpu_pkg::D_WIDTH,
  parameter int REG_L2     = cpu_pkg::REG_L2,
  parameter int FIFO_DEPTH = 4
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic               alu_valid;
  logic               alu_ready;
  logic [REG_L2-1:0]  alu_rd;
  logic [D_WIDTH-1:0] alu_data;
  logic               lsu_valid;
  logic               lsu_ready;
  logic [REG_L2-1:0]  lsu_rd;
  logic [D_WIDTH-1:0] lsu_data;
  logic               we;
  logic [REG_L2-1:0]  w_addr;
  logic [D_WIDTH-1:0] w_data;
  logic [CW-1:0]      fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready, we, w_addr, w_data, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready, we, w_addr, w_data, fifo_count
  );

endinterface

// File: rtl/rf_wb_arb_fifo.sv
// Circular buffer of writeback requests: registered count, head visible combinationally.
// Push is ignored when full and pop when empty; push+pop together leaves the count unchanged.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = wb_req_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rf_wb_arb.sv
// Writeback arbiter: ALU (1-cycle) and FIFO-buffered LSU (2-cycle min) share one registered RF write port;
// ALU wins unless the FIFO is full, both readys drop only when full. RF_WB_FWD_EN adds an empty-FIFO LSU bypass.
module rf_wb_arb
  import cpu_pkg::*;
#(
  parameter int D_WIDTH    = cpu_pkg::D_WIDTH,
  parameter int N_REGS     = cpu_pkg::N_REGS,
  parameter int REG_L2     = $clog2(N_REGS),
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  rf_wb_arb_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Same layout as wb_req_t, sized from this instance's parameters.
  typedef struct packed {
    logic [REG_L2-1:0]  rd;
    logic [D_WIDTH-1:0] data;
  } req_t;

  req_t          alu_req;
  req_t          lsu_req;
  req_t          head;
  req_t          win;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          slot;
  logic          byp;
  logic [CW-1:0] count;

  assign alu_req        = {bus.alu_rd, bus.alu_data};
  assign lsu_req        = {bus.lsu_rd, bus.lsu_data};
  assign bus.alu_ready  = !fifo_full;
  assign bus.lsu_ready  = !fifo_full;
  assign bus.fifo_count = count;

`ifdef RF_WB_FWD_EN
  assign byp = fifo_empty && !bus.alu_valid && bus.lsu_valid;
`else
  assign byp = 1'b0;
`endif

  assign push = bus.lsu_valid && !fifo_full && !byp;

  // A full FIFO must drain to restore LSU acceptance, so it outranks the ALU.
  always_comb begin
    pop  = 1'b0;
    slot = 1'b0;
    win  = head;
    if (fifo_full) begin
      pop  = 1'b1;
      slot = 1'b1;
    end else if (bus.alu_valid) begin
      slot = 1'b1;
      win  = alu_req;
    end else if (!fifo_empty) begin
      pop  = 1'b1;
      slot = 1'b1;
    end else if (byp) begin
      slot = 1'b1;
      win  = lsu_req;
    end
  end

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (req_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (lsu_req),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  // rd==0 results still take the slot and update addr/data; only we is masked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.we     <= 1'b0;
      bus.w_addr <= '0;
      bus.w_data <= '0;
    end else if (slot) begin
      bus.we     <= (win.rd != REG_L2'(REG_ZERO));
      bus.w_addr <= win.rd;
      bus.w_data <= win.data;
    end else begin
      bus.we     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wb_arb.sv
// Bench for rf_wb_arb: directed vector table, hand-written reset/bypass sequences,
// then randomized traffic against a queue-based reference model.
module tb_rf_wb_arb;
  import cpu_pkg::*;

  localparam int DW    = 32;
  localparam int RL    = 5;
  localparam int DEPTH = 4;
`ifdef RF_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rf_wb_arb_if #(.D_WIDTH(DW), .REG_L2(RL), .FIFO_DEPTH(DEPTH)) bus ();

  rf_wb_arb #(
    .D_WIDTH    (DW),
    .N_REGS     (32),
    .REG_L2     (RL),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        ear;
    logic        elr;
    logic        ewe;
    logic [4:0]  eaddr;
    logic [31:0] edat;
    logic [2:0]  ecnt;
  } vec_t;

  vec_t vt [22];

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                              input logic ear, input logic elr, input logic ewe,
                              input logic [4:0] eaddr, input logic [31:0] edat, input logic [2:0] ecnt);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.ear = ear; v.elr = elr; v.ewe = ewe; v.eaddr = eaddr; v.edat = edat; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.lsu_valid = lv;
    bus.lsu_rd    = lrd;
    bus.lsu_data  = ld;
  endtask

  task automatic chk_out(input string tag, input logic ewe, input logic [4:0] eaddr,
                         input logic [31:0] edat, input logic [2:0] ecnt);
    chk({tag, " we"},         bus.we,         ewe);
    chk({tag, " w_addr"},     bus.w_addr,     eaddr);
    chk({tag, " w_data"},     bus.w_data,     edat);
    chk({tag, " fifo_count"}, bus.fifo_count, ecnt);
  endtask

  // Reference model state for the random phase
  wb_req_t     q [$];
  wb_req_t     w;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        full, got, bypassed;
  logic        a_v, l_v, a_stall, l_stall;
  logic [4:0]  a_rd, l_rd;
  logic [31:0] a_d, l_d;
  int          pa;

  initial begin
    // ALU only, rd 0, LSU buffering behind a busy ALU, drain, push/pop at count 2 with wrap
    vt[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  0,          1, 1, 1, 5,  32'hDEADBEEF, 0);
    vt[1]  = mk(1, 0,  32'h1234,     0, 0,  0,          1, 1, 0, 0,  32'h1234,     0);
    vt[2]  = mk(1, 6,  32'h66,       1, 0,  32'hAAAA,   1, 1, 1, 6,  32'h66,       1);
    vt[3]  = mk(0, 0,  0,            0, 0,  0,          1, 1, 0, 0,  32'hAAAA,     0);
    vt[4]  = mk(0, 0,  0,            0, 0,  0,          1, 1, 0, 0,  32'hAAAA,     0);
    vt[5]  = mk(1, 10, 32'hA0,       1, 1,  32'h101,    1, 1, 1, 10, 32'hA0,       1);
    vt[6]  = mk(1, 11, 32'hA1,       1, 2,  32'h102,    1, 1, 1, 11, 32'hA1,       2);
    vt[7]  = mk(1, 12, 32'hA2,       1, 3,  32'h103,    1, 1, 1, 12, 32'hA2,       3);
    vt[8]  = mk(1, 13, 32'hA3,       1, 4,  32'h104,    1, 1, 1, 13, 32'hA3,       4);
    vt[9]  = mk(1, 14, 32'hA4,       0, 0,  0,          0, 0, 1, 1,  32'h101,      3);
    vt[10] = mk(1, 14, 32'hA4,       0, 0,  0,          1, 1, 1, 14, 32'hA4,       3);
    vt[11] = mk(0, 0,  0,            0, 0,  0,          1, 1, 1, 2,  32'h102,      2);
    vt[12] = mk(1, 15, 32'hA5,       0, 0,  0,          1, 1, 1, 15, 32'hA5,       2);
    vt[13] = mk(0, 0,  0,            0, 0,  0,          1, 1, 1, 3,  32'h103,      1);
    vt[14] = mk(0, 0,  0,            0, 0,  0,          1, 1, 1, 4,  32'h104,      0);
    vt[15] = mk(1, 16, 32'hB0,       1, 7,  32'h107,    1, 1, 1, 16, 32'hB0,       1);
    vt[16] = mk(1, 17, 32'hB1,       1, 8,  32'h108,    1, 1, 1, 17, 32'hB1,       2);
    vt[17] = mk(0, 0,  0,            1, 9,  32'h109,    1, 1, 1, 7,  32'h107,      2);
    vt[18] = mk(0, 0,  0,            1, 10, 32'h10A,    1, 1, 1, 8,  32'h108,      2);
    vt[19] = mk(0, 0,  0,            0, 0,  0,          1, 1, 1, 9,  32'h109,      1);
    vt[20] = mk(0, 0,  0,            0, 0,  0,          1, 1, 1, 10, 32'h10A,      0);
    vt[21] = mk(0, 0,  0,            0, 0,  0,          1, 1, 0, 10, 32'h10A,      0);

    drive(0, 0, 0, 0, 0, 0);
    #12;
    chk_out("reset", 0, 0, 0, 0);
    chk("reset alu_ready", bus.alu_ready, 1);
    chk("reset lsu_ready", bus.lsu_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(vt[i].av, vt[i].ard, vt[i].ad, vt[i].lv, vt[i].lrd, vt[i].ld);
      #1;
      chk($sformatf("v%0d alu_ready", i), bus.alu_ready, vt[i].ear);
      chk($sformatf("v%0d lsu_ready", i), bus.lsu_ready, vt[i].elr);
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", i), vt[i].ewe, vt[i].eaddr, vt[i].edat, vt[i].ecnt);
    end

    // Reset asserted mid-cycle while three LSU entries wait to drain
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(20 + i), 32'(32'hC0 + i), 1, 5'(1 + i), 32'(32'h200 + i));
      @(posedge clk);
      #1;
    end
    chk_out("predrain", 1, 22, 32'hC2, 3);
    drive(0, 0, 0, 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    chk_out("async rst", 0, 0, 0, 0);
    chk("async rst alu_ready", bus.alu_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk_out($sformatf("post rst %0d", i), 0, 0, 0, 0);
    end

    // Lone LSU result into an empty FIFO
    drive(0, 0, 0, 1, 7, 32'h55);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
`ifdef RF_WB_FWD_EN
    chk_out("fwd lsu", 1, 7, 32'h55, 0);
    @(posedge clk);
    #1;
    chk_out("fwd idle", 0, 7, 32'h55, 0);
`else
    chk_out("lsu push", 0, 0, 0, 1);
    @(posedge clk);
    #1;
    chk_out("lsu pop", 1, 7, 32'h55, 0);
`endif

    // Randomized traffic against the queue model, from a fresh reset
    rst = 1'b1;
    #2;
    rst = 1'b0;
    q.delete();
    m_addr  = '0;
    m_data  = '0;
    a_v = 0; l_v = 0; a_rd = 0; l_rd = 0; a_d = 0; l_d = 0;
    a_stall = 0;
    l_stall = 0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3000; c++) begin
      pa = (c < 1500) ? 75 : 35;
      if (!a_stall) begin
        a_v  = ($urandom_range(0, 99) < pa);
        a_rd = 5'($urandom_range(0, 31));
        a_d  = $urandom;
      end
      if (!l_stall) begin
        l_v  = ($urandom_range(0, 99) < 45);
        l_rd = 5'($urandom_range(0, 31));
        l_d  = $urandom;
      end
      drive(a_v, a_rd, a_d, l_v, l_rd, l_d);
      full = (q.size() == DEPTH);
      #1;
      chk($sformatf("rnd%0d alu_ready", c), bus.alu_ready, !full);
      chk($sformatf("rnd%0d lsu_ready", c), bus.lsu_ready, !full);

      got      = 1'b0;
      bypassed = 1'b0;
      if (full) begin
        w   = q.pop_front();
        got = 1'b1;
      end else if (a_v) begin
        w   = '{rd: a_rd, data: a_d};
        got = 1'b1;
      end else if (q.size() != 0) begin
        w   = q.pop_front();
        got = 1'b1;
      end else if (FWD && l_v) begin
        w        = '{rd: l_rd, data: l_d};
        got      = 1'b1;
        bypassed = 1'b1;
      end
      if (l_v && !full && !bypassed) q.push_back('{rd: l_rd, data: l_d});
      a_stall = a_v && full;
      l_stall = l_v && full;
      if (got) begin
        m_we   = (w.rd != 0);
        m_addr = w.rd;
        m_data = w.data;
      end else begin
        m_we = 1'b0;
      end

      @(posedge clk);
      #1;
      chk_out($sformatf("rnd%0d", c), m_we, m_addr, m_data, 3'(q.size()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arb.md
Name: rf_wb_arb

Overview:
- Writeback-side driver of the register file's single synchronous write port; produces `we`/`w_addr`/`w_data`.
- Merges two producers into that one port:
  - single-cycle ALU results;
  - variable-latency load/mul-div (LSU) results.
- LSU results are buffered in a small FIFO. ALU has priority unless the FIFO is full.
- Writes to register 0 are consumed but never asserted on the port.

Parameters:
- D_WIDTH, 32, data width of each write.
- N_REGS, 32, number of architectural registers.
- REG_L2, $clog2(N_REGS), register address width.
- FIFO_DEPTH, 4, LSU buffer entries; must be a power of two and at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  REG_L2  ALU destination register.
- alu_data  in  D_WIDTH  ALU result.
- lsu_valid  in  1  LSU result present.
- lsu_ready  out  1  LSU result accepted this cycle (equals !full).
- lsu_rd  in  REG_L2  LSU destination register.
- lsu_data  in  D_WIDTH  LSU result.
- we  out  1  register-file write enable (registered).
- w_addr  out  REG_L2  register-file write address (registered).
- w_data  out  D_WIDTH  register-file write data (registered).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy (registered).

Behaviour:
- Reset (asynchronous, any cycle, including mid-drain):
  - we=0, w_addr=0, w_data=0, fifo_count=0.
  - FIFO pointers cleared; buffered entries are discarded.
- Handshakes:
  - A transfer occurs when valid && ready on a rising edge.
  - Producers hold rd/data stable while valid && !ready.
  - lsu_ready = (fifo_count != FIFO_DEPTH). It is combinational from registered state only.
- Arbitration (one write slot per cycle), in priority order:
  1. FIFO full → FIFO head wins; alu_ready=0.
  2. alu_valid → ALU wins; alu_ready=1.
  3. Otherwise, FIFO non-empty → FIFO head wins.
  4. Otherwise → no write.
- alu_ready is combinational: = !(fifo_count == FIFO_DEPTH).
- Output register, on each edge:
  - If a slot was granted: w_addr/w_data load the winner's values; we = (winner rd != 0).
  - If no slot was granted: we=0; w_addr/w_data hold their previous values.
- Latency:
  - ALU: accept → we high on the next cycle (1 cycle).
  - LSU: push at edge N; earliest pop at edge N+1; we high after edge N+1 (2 cycles minimum).
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle is legal when not full; count is unchanged.
  - Full: no push (lsu_ready=0); pop forced by rule 1.
  - Empty: no pop.
- Ordering:
  - LSU results retire in acceptance order.
  - No ordering is enforced between ALU and LSU to the same rd. The issue stage must not issue an overlapping rd (WAW).
- rd==0 entries still consume a slot and a FIFO entry; only `we` is suppressed.

Optional Feature:
- Macro: RF_WB_FWD_EN.
- Enabled: bypass path. When the FIFO is empty, alu_valid=0 and lsu_valid=1, the LSU result goes straight to the output register without entering the FIFO:
  - LSU latency drops to 1 cycle;
  - fifo_count stays 0.
- Disabled: every LSU result passes through the FIFO (2-cycle minimum).
- In both modes, port list, reset values and ALU behaviour are identical.

Decomposition:
- Shared package cpu_pkg holds:
  - D_WIDTH and REG_L2 constants;
  - typedef wb_req_t, a struct of {rd, data};
  - localparam REG_ZERO = 0.
- Sub-module wb_fifo (parameterised by depth and wb_req_t) provides push/pop/full/empty/count.
- Arbitration and the output register stay in rf_wb_arb.

Test Plan:
- ALU only: alu_valid=1, rd=5, data=0xDEADBEEF → next cycle we=1, w_addr=5, w_data=0xDEADBEEF; alu_ready=1 throughout.
- rd zero: ALU rd=0, data=0x1234 → alu_ready=1, we stays 0; then LSU rd=0 → fifo_count 1→0, we stays 0.
- LSU buffering:
  - with ALU busy every cycle, push 4 LSU results (rd 1..4) → fifo_count=4, lsu_ready=0;
  - next cycle alu_ready=0 and rd 1 is written;
  - ALU resumes once count<4, and rd 2..4 drain in order whenever alu_valid drops.
- Simultaneous push/pop at count=2 with alu_valid=0 → count stays 2; head written; tail stored; wrap-around is exercised after 6 total pushes.
- Reset mid-drain: count=3, assert rst asynchronously → we=0, w_addr=0, w_data=0, fifo_count=0 immediately; no stale write after release.
- RF_WB_FWD_EN: FIFO empty, alu_valid=0, LSU rd=7, data=0x55 → we=1 on the next cycle and fifo_count stays 0. Without the macro: fifo_count=1, and we is asserted one cycle later.
